// File: rtl/sdram_port_arbiter.sv
// Round-robin front end that multiplexes client write/burst-read requests onto
// the SDRAM controller command interface and routes completions back to the owner.
module sdram_port_arbiter #(
    parameter int unsigned Channels    = 2,
    parameter int unsigned AddrWidth   = 25,
    parameter int unsigned DataWidth   = 16,
    parameter int unsigned BurstLength = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [Channels-1:0]            req_valid_i,
    output logic [Channels-1:0]            req_ready_o,
    input  logic [Channels-1:0]            req_write_i,
    input  logic [Channels*AddrWidth-1:0]  req_addr_i,
    input  logic [Channels*DataWidth-1:0]  req_wdata_i,
    output logic [DataWidth-1:0]           rd_data_o,
    output logic [Channels-1:0]            rd_valid_o,
    output logic [Channels-1:0]            wr_done_o,
    output logic                           busy_o,
    output logic [1:0]                     mem_command_o,
    output logic [AddrWidth-1:0]           mem_address_o,
    output logic [DataWidth-1:0]           mem_write_data_o,
    input  logic [DataWidth-1:0]           mem_read_data_i,
    input  logic                           mem_read_valid_i,
    input  logic                           mem_write_done_i
);

    localparam int unsigned ChW  = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int unsigned CntW = $clog2(BurstLength) + 1;

    localparam logic [1:0] CmdIdle  = 2'd0;
    localparam logic [1:0] CmdWrite = 2'd1;
    localparam logic [1:0] CmdRead  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_e;

    state_e                state_q;
    logic [ChW-1:0]        last_q;
    logic [ChW-1:0]        owner_q;
    logic                  write_q;
    logic [CntW-1:0]       beat_q;
    logic [1:0]            cmd_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [DataWidth-1:0]  wdata_q;
    logic [DataWidth-1:0]  rd_data_q;
    logic [Channels-1:0]   rd_valid_q;
    logic [Channels-1:0]   wr_done_q;
    logic                  busy_q;

    logic                  grant_found_d;
    logic [ChW-1:0]        grant_d;
    logic [ChW-1:0]        cand_d;

    // Round-robin pick: first requester at or after last_q+1, wrapping.
    always_comb begin
        grant_found_d = 1'b0;
        grant_d       = '0;
        cand_d        = '0;
        for (int unsigned i = 1; i <= Channels; i++) begin
            cand_d = ChW'((32'(last_q) + i) % Channels);
            if (!grant_found_d && req_valid_i[cand_d]) begin
                grant_found_d = 1'b1;
                grant_d       = cand_d;
            end
        end
    end

    // Reset gating keeps the accept pulse low while reset is held.
    assign req_ready_o = (!rst_i && (state_q == IDLE) && grant_found_d)
                       ? (Channels'(1) << grant_d) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= ChW'(Channels - 1);
            owner_q    <= '0;
            write_q    <= 1'b0;
            beat_q     <= '0;
            cmd_q      <= CmdIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            wr_done_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            rd_valid_q <= '0;
            wr_done_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (grant_found_d) begin
                        owner_q <= grant_d;
                        last_q  <= grant_d;
                        write_q <= req_write_i[grant_d];
                        addr_q  <= req_addr_i[grant_d*AddrWidth +: AddrWidth];
                        wdata_q <= req_wdata_i[grant_d*DataWidth +: DataWidth];
                        cmd_q   <= req_write_i[grant_d] ? CmdWrite : CmdRead;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Only the completion type matching the issued command counts.
                    if (write_q) begin
                        if (mem_write_done_i) begin
                            wr_done_q <= Channels'(1) << owner_q;
                            cmd_q     <= CmdIdle;
                            state_q   <= GAP;
                        end
                    end else if (mem_read_valid_i) begin
                        rd_valid_q <= Channels'(1) << owner_q;
                        rd_data_q  <= mem_read_data_i;
                        if (beat_q == CntW'(BurstLength - 1)) begin
                            beat_q  <= '0;
                            cmd_q   <= CmdIdle;
                            state_q <= GAP;
                        end else begin
                            beat_q <= beat_q + CntW'(1);
                        end
                    end
                end
                GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    cmd_q   <= CmdIdle;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_data_o        = rd_data_q;
    assign rd_valid_o       = rd_valid_q;
    assign wr_done_o        = wr_done_q;
    assign busy_o           = busy_q;
    assign mem_command_o    = cmd_q;
    assign mem_address_o    = addr_q;
    assign mem_write_data_o = wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (3 channels, burst of 4) with a
// transaction-level reference model checked every cycle plus literal event logs.
module tb_sdram_port_arbiter;

    localparam int CH = 3;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BL = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    req_valid = '0;
    logic [CH-1:0]    req_write = '0;
    logic [CH*AW-1:0] req_addr  = '0;
    logic [CH*DW-1:0] req_wdata = '0;
    logic [DW-1:0]    rdata = '0;
    logic             rv = 1'b0;
    logic             wd = 1'b0;

    logic [CH-1:0]    req_ready_o;
    logic [DW-1:0]    rd_data_o;
    logic [CH-1:0]    rd_valid_o;
    logic [CH-1:0]    wr_done_o;
    logic             busy_o;
    logic [1:0]       mem_command_o;
    logic [AW-1:0]    mem_address_o;
    logic [DW-1:0]    mem_write_data_o;

    sdram_port_arbiter #(
        .Channels(CH), .AddrWidth(AW), .DataWidth(DW), .BurstLength(BL)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .wr_done_o(wr_done_o),
        .busy_o(busy_o), .mem_command_o(mem_command_o),
        .mem_address_o(mem_address_o), .mem_write_data_o(mem_write_data_o),
        .mem_read_data_i(rdata), .mem_read_valid_i(rv), .mem_write_done_i(wd)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int timeouts = 0;
    bit stim_done = 1'b0;

    // ---------------- reference model: one outstanding transaction ----------------
    bit            m_active = 1'b0;
    bit            m_gap    = 1'b0;
    int            m_ch     = 0;
    int            m_last   = CH - 1;
    bit            m_wr     = 1'b0;
    int            m_beats  = 0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [CH-1:0] e_rdv    = '0;
    logic [DW-1:0] e_rdd    = '0;
    logic [CH-1:0] e_wrd    = '0;
    int            pick_now;

    function automatic int pick(input logic [CH-1:0] v, input int last);
        for (int k = 1; k <= CH; k++) begin
            int c;
            c = (last + k) % CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always_comb pick_now = pick(req_valid, m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0; m_gap <= 1'b0; m_last <= CH - 1; m_beats <= 0;
            m_addr <= '0; m_wdata <= '0; e_rdv <= '0; e_rdd <= '0; e_wrd <= '0;
        end else begin
            e_rdv <= '0;
            e_wrd <= '0;
            if (m_gap) begin
                m_gap <= 1'b0;
            end else if (!m_active) begin
                if (pick_now >= 0) begin
                    m_active <= 1'b1;
                    m_ch     <= pick_now;
                    m_last   <= pick_now;
                    m_wr     <= req_write[pick_now];
                    m_addr   <= req_addr[pick_now*AW +: AW];
                    m_wdata  <= req_wdata[pick_now*DW +: DW];
                    m_beats  <= 0;
                end
            end else if (m_wr) begin
                if (wd) begin
                    e_wrd <= 3'b001 << m_ch;
                    m_active <= 1'b0;
                    m_gap    <= 1'b1;
                end
            end else if (rv) begin
                e_rdv <= 3'b001 << m_ch;
                e_rdd <= rdata;
                m_beats <= m_beats + 1;
                if (m_beats + 1 == BL) begin
                    m_active <= 1'b0;
                    m_gap    <= 1'b1;
                end
            end
        end
    end

    // ---------------- comparison ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [1:0]    x_cmd [10] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
    logic [AW-1:0] x_addr[10] = '{25'h10, 25'hABC, 25'h100, 25'h500, 25'h600,
                                  25'h300, 25'h400, 25'h600, 25'h300, 25'h400};
    logic [DW-1:0] x_wdat[10] = '{16'h5555, 16'h1234, 16'h5555, 16'h0000, 16'h5555,
                                  16'h1111, 16'h2222, 16'h5555, 16'h1111, 16'h2222};
    logic [CH-1:0] x_rown[14] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 3'd4, 3'd1,
                                  3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    logic [DW-1:0] x_rdat[14] = '{16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hB0, 16'hB1, 16'hC0,
                                  16'hC1, 16'hC2, 16'hC3, 16'hC0, 16'hC1, 16'hC2, 16'hC3};
    logic [CH-1:0] x_wown[6]  = '{3'd1, 3'd2, 3'd2, 3'd4, 3'd2, 3'd4};

    logic [1:0]    lg_cmd [$];
    logic [AW-1:0] lg_addr[$];
    logic [DW-1:0] lg_wdat[$];
    logic [CH-1:0] lg_rown[$];
    logic [DW-1:0] lg_rdat[$];
    logic [CH-1:0] lg_wown[$];

    initial begin : compare
        logic [1:0]    exp_cmd;
        logic [CH-1:0] exp_rdy;
        logic [1:0]    prev_cmd;
        prev_cmd = 2'd0;
        while (!stim_done) begin
            @(posedge clk or posedge rst);
            #1;
            exp_cmd = m_active ? (m_wr ? 2'd1 : 2'd2) : 2'd0;
            exp_rdy = (!rst && !m_active && !m_gap && pick_now >= 0)
                    ? (3'b001 << pick_now) : 3'b000;
            chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
            chk("busy", 64'(busy_o), 64'(m_active || m_gap));
            chk("mem_command", 64'(mem_command_o), 64'(exp_cmd));
            chk("mem_address", 64'(mem_address_o), 64'(m_addr));
            chk("mem_write_data", 64'(mem_write_data_o), 64'(m_wdata));
            chk("rd_valid", 64'(rd_valid_o), 64'(e_rdv));
            chk("rd_data", 64'(rd_data_o), 64'(e_rdd));
            chk("wr_done", 64'(wr_done_o), 64'(e_wrd));
            if (mem_command_o != 2'd0 && prev_cmd == 2'd0) begin
                lg_cmd.push_back(mem_command_o);
                lg_addr.push_back(mem_address_o);
                lg_wdat.push_back(mem_write_data_o);
            end
            prev_cmd = mem_command_o;
            if (rd_valid_o != '0) begin
                lg_rown.push_back(rd_valid_o);
                lg_rdat.push_back(rd_data_o);
            end
            if (wr_done_o != '0) lg_wown.push_back(wr_done_o);
        end
        chk("cmdlog.size", 64'(lg_cmd.size()), 64'(10));
        for (int i = 0; i < 10 && i < lg_cmd.size(); i++) begin
            chk($sformatf("cmdlog[%0d].cmd", i), 64'(lg_cmd[i]), 64'(x_cmd[i]));
            chk($sformatf("cmdlog[%0d].addr", i), 64'(lg_addr[i]), 64'(x_addr[i]));
            chk($sformatf("cmdlog[%0d].wdata", i), 64'(lg_wdat[i]), 64'(x_wdat[i]));
        end
        chk("rdlog.size", 64'(lg_rown.size()), 64'(14));
        for (int i = 0; i < 14 && i < lg_rown.size(); i++) begin
            chk($sformatf("rdlog[%0d].owner", i), 64'(lg_rown[i]), 64'(x_rown[i]));
            chk($sformatf("rdlog[%0d].data", i), 64'(lg_rdat[i]), 64'(x_rdat[i]));
        end
        chk("wrlog.size", 64'(lg_wown.size()), 64'(6));
        for (int i = 0; i < 6 && i < lg_wown.size(); i++)
            chk($sformatf("wrlog[%0d].owner", i), 64'(lg_wown[i]), 64'(x_wown[i]));
        chk("wait_timeouts", 64'(timeouts), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    // One cycle: note accepts just before the edge, then update inputs 2 units after it.
    task automatic cyc();
        logic [CH-1:0] acc;
        @(negedge clk);
        acc = req_ready_o & req_valid;
        @(posedge clk);
        #2;
        req_valid = req_valid & ~acc;
        rv = 1'b0;
        wd = 1'b0;
    endtask

    task automatic set_req(input int ch, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[ch]         = 1'b1;
        req_write[ch]         = wr;
        req_addr[ch*AW +: AW] = a;
        req_wdata[ch*DW +: DW] = d;
    endtask

    task automatic wait_cmd();
        int n = 0;
        while (mem_command_o == 2'd0 && n < 30) begin cyc(); n++; end
        if (mem_command_o == 2'd0) timeouts++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 30) begin cyc(); n++; end
        if (busy_o) timeouts++;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        rv = 1'b1;
        rdata = d;
        cyc();
    endtask

    initial begin : stimulus
        // Simultaneous ch0/ch1 writes pending across reset release.
        set_req(0, 1'b1, 25'h10, 16'h5555);
        set_req(1, 1'b1, 25'hABC, 16'h1234);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_cmd();
        repeat (2) cyc();
        wd = 1'b1;
        cyc();
        // ch1 write, with a wrong-type read beat injected.
        wait_cmd();
        rv = 1'b1;
        rdata = 16'h7777;
        cyc();
        repeat (3) cyc();
        wd = 1'b1;
        cyc();
        wait_idle();

        // Spurious beat in IDLE, then ch0 burst read with a stray write-done.
        rv = 1'b1;
        rdata = 16'h00EE;
        cyc();
        set_req(0, 1'b0, 25'h100, 16'h5555);
        wait_cmd();
        wd = 1'b1;
        cyc();
        for (int b = 0; b < 4; b++) beat(16'(16'hA0 + b));
        wait_idle();

        // ch2 burst read interrupted by reset after two beats.
        set_req(2, 1'b0, 25'h500, 16'h0000);
        wait_cmd();
        beat(16'hB0);
        beat(16'hB1);
        set_req(0, 1'b0, 25'h600, 16'h5555);
        cyc();
        #2;
        rst = 1'b1;
        rv = 1'b1;
        rdata = 16'hB2;
        cyc();
        cyc();
        rst = 1'b0;

        // All three channels request continuously: expect 0,1,2,0,1,2.
        set_req(1, 1'b1, 25'h300, 16'h1111);
        set_req(2, 1'b1, 25'h400, 16'h2222);
        for (int i = 0; i < 6; i++) begin
            wait_cmd();
            if (mem_command_o == 2'd2) begin
                for (int b = 0; b < 4; b++) beat(16'(16'hC0 + b));
            end else begin
                repeat (2) cyc();
                wd = 1'b1;
                cyc();
            end
            req_valid = (i < 5) ? 3'b111 : 3'b000;
        end
        wait_idle();
        repeat (3) cyc();
        stim_done = 1'b1;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Multi-channel front end for the SDRAM controller. It accepts single-word write and burst-read requests from `Channels` independent clients over valid/ready handshakes and arbitrates between them round-robin. It drives the controller's command/address/data interface and routes returned read beats and write completions back to the requesting channel. It sits between the accelerator's memory clients (weight loader, frame buffer, debug port) and the board-level SDRAM wrapper, in the SDRAM clock domain.

## Interface
- `Channels`, 2: number of client ports, 2..8.
- `AddrWidth`, 25: bank+row+column address width.
- `DataWidth`, 16: data word width.
- `BurstLength`, 1: read beats per read command (1, 2, 4, 8); must match the controller setting.

Ports:
- `clk_i`  in  1  SDRAM-domain clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  Channels  per-channel request valid.
- `req_ready_o`  out  Channels  one-hot accept pulse.
- `req_write_i`  in  Channels  per-channel: 1 = write, 0 = read.
- `req_addr_i`  in  Channels*AddrWidth  packed addresses; channel k at [k*AddrWidth +: AddrWidth].
- `req_wdata_i`  in  Channels*DataWidth  packed write data.
- `rd_data_o`  out  DataWidth  shared read data.
- `rd_valid_o`  out  Channels  one-hot; marks the owner of `rd_data_o`.
- `wr_done_o`  out  Channels  one-hot write-completion pulse.
- `busy_o`  out  1  high whenever the FSM is not IDLE.
- `mem_command_o`  out  2  0 idle, 1 write, 2 read.
- `mem_address_o`  out  AddrWidth  controller address.
- `mem_write_data_o`  out  DataWidth  controller write data.
- `mem_read_data_i`  in  DataWidth  controller read data.
- `mem_read_valid_i`  in  1  controller read beat valid.
- `mem_write_done_i`  in  1  controller write done.

## Operation
- FSM states: IDLE, ISSUE, GAP.
- IDLE: if any `req_valid_i` is set, grant the first requesting channel searching upward (with wrap) from `last_grant+1`.
  - Pulse `req_ready_o[g]` combinationally in the same cycle.
  - Latch write flag, address and wdata for channel g; set `last_grant = g`; go to ISSUE.
- ISSUE: `mem_command_o` = 1 or 2, with address and data held stable from the latched values.
  - Write: stay until `mem_write_done_i`; then pulse `wr_done_o[g]` and go to GAP.
  - Read: count `mem_read_valid_i` beats (counter width `$clog2(BurstLength)+1`). Each beat produces `rd_data_o` = beat and `rd_valid_o[g]` = 1. After beat `BurstLength` go to GAP; the counter clears.
- GAP: `mem_command_o` = 0 for exactly one cycle, so the controller sees command deassertion. Then go to IDLE.
- `mem_read_valid_i` and `mem_write_done_i` outside ISSUE, or of the wrong type for the current command, are ignored and produce no client output.
- A channel is never granted twice in a row while another channel is requesting.
- Requests are not buffered: a client holds `req_valid_i` and its payload until it sees `req_ready_o`.
- Reset: FSM to IDLE and `last_grant = Channels-1`, so channel 0 has first priority. All outputs are 0: `req_ready_o`, `rd_data_o`, `rd_valid_o`, `wr_done_o`, `busy_o`, `mem_command_o`, `mem_address_o`, `mem_write_data_o`.
- Reset mid-operation: the command drops to idle asynchronously and the in-flight request is discarded with no completion pulse.

## Timing
- Accept at cycle T (valid & ready): `mem_command_o` non-zero from T+1; `busy_o` high from T+1.
- `rd_valid_o`/`rd_data_o` are registered: beat at cycle R appears at R+1. `wr_done_o` follows `mem_write_done_i` at W by one cycle (W+1).
- Final read beat at R or write done at W: GAP at R+1/W+1, IDLE at R+2/W+2, so the next accept is possible at R+2/W+2.
- Minimum request-to-request spacing is ISSUE duration + 2 cycles.
- `req_ready_o` is high only in IDLE and at most one bit at a time.

## Test plan
- Reset values: assert `rst_i` asynchronously mid-cycle -> all outputs 0 immediately; after release, channel 0 wins a simultaneous 0/1 request.
- Single write: ch1 writes 0x1234 @ 0x0000ABC; controller returns done 5 cycles after the command -> `mem_command_o`=1 with addr 0x0000ABC and data 0x1234; `wr_done_o`=2'b10 one cycle after done; GAP cycle with command 0.
- Burst read, `BurstLength`=4: ch0 reads @ 0x100; controller supplies 0xA0..0xA3 -> `rd_valid_o`=2'b01 for 4 consecutive cycles carrying 0xA0..0xA3 in order, then GAP, then IDLE.
- Fairness, `Channels`=3: all channels request continuously -> grant order 0,1,2,0,1,2; no channel is granted twice consecutively.
- Spurious inputs: pulse `mem_read_valid_i` in IDLE and `mem_write_done_i` during a read -> no `rd_valid_o`/`wr_done_o` and no state change.
- Reset during a burst read after beat 2 of 4 -> command idle, no further `rd_valid_o`; the next request is served normally.
